// File: rtl/pmod_byte_deserializer.sv
// PMOD byte-stream receiver: reassembles NBYTES bytes (MSB first) into one word behind a one-word holding buffer.
// Optional zero-header checking is compiled in with `define PMOD_RX_HDR_CHECK_EN.
module pmod_byte_deserializer #(
    parameter int NBYTES    = 32,
    parameter int HDR_BYTES = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [7:0]            pmod_input,
    input  logic                  pmod_valid,
    output logic [8*NBYTES-1:0]   word_tdata,
    output logic                  word_tvalid,
    input  logic                  word_tready,
    output logic                  frame_err,
    output logic [7:0]            led_output
);

    localparam int W   = 8 * NBYTES;
    localparam int BCW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef PMOD_RX_HDR_CHECK_EN
        HDR  = 2'd1,
`endif
        DATA = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     asm_q, asm_d;
    logic [BCW-1:0]   byteCnt_q, byteCnt_d;
    logic [7:0]       gapCnt_q, gapCnt_d;
    logic [W-1:0]     buf_q, buf_d;
    logic             bufValid_q, bufValid_d;
    logic             frameErr_q, frameErr_d;
    logic [3:0]       errCnt_q, errCnt_d;
    logic [3:0]       frameCnt_q, frameCnt_d;
`ifdef PMOD_RX_HDR_CHECK_EN
    localparam int HCW = $clog2(HDR_BYTES + 1);
    logic [HCW-1:0]   hdrCnt_q, hdrCnt_d;
`endif

    logic accept;
    logic shiftByte;
    logic complete;
    logic errEvt;

    assign accept = bufValid_q & word_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            asm_q      <= '0;
            byteCnt_q  <= '0;
            gapCnt_q   <= '0;
            buf_q      <= '0;
            bufValid_q <= 1'b0;
            frameErr_q <= 1'b0;
            errCnt_q   <= '0;
            frameCnt_q <= '0;
`ifdef PMOD_RX_HDR_CHECK_EN
            hdrCnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            asm_q      <= asm_d;
            byteCnt_q  <= byteCnt_d;
            gapCnt_q   <= gapCnt_d;
            buf_q      <= buf_d;
            bufValid_q <= bufValid_d;
            frameErr_q <= frameErr_d;
            errCnt_q   <= errCnt_d;
            frameCnt_q <= frameCnt_d;
`ifdef PMOD_RX_HDR_CHECK_EN
            hdrCnt_q   <= hdrCnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        asm_d      = asm_q;
        byteCnt_d  = byteCnt_q;
        gapCnt_d   = '0;
        buf_d      = buf_q;
        bufValid_d = bufValid_q;
        errCnt_d   = errCnt_q;
        frameCnt_d = frameCnt_q;
        shiftByte  = 1'b0;
        complete   = 1'b0;
        errEvt     = 1'b0;
`ifdef PMOD_RX_HDR_CHECK_EN
        hdrCnt_d   = hdrCnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (pmod_valid) begin
`ifdef PMOD_RX_HDR_CHECK_EN
                    if (pmod_input != 8'h00) begin
                        errEvt = 1'b1;
                    end else if (HDR_BYTES == 1) begin
                        state_d = DATA;
                    end else begin
                        state_d  = HDR;
                        hdrCnt_d = HCW'(1);
                    end
`else
                    shiftByte = 1'b1;
`endif
                end
            end
`ifdef PMOD_RX_HDR_CHECK_EN
            HDR: begin
                if (pmod_valid) begin
                    if (pmod_input != 8'h00) begin
                        errEvt   = 1'b1;
                        state_d  = IDLE;
                        hdrCnt_d = '0;
                    end else if (hdrCnt_q == HCW'(HDR_BYTES - 1)) begin
                        state_d  = DATA;
                        hdrCnt_d = '0;
                    end else begin
                        hdrCnt_d = hdrCnt_q + HCW'(1);
                    end
                end
            end
`endif
            DATA: begin
                if (pmod_valid) begin
                    shiftByte = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Idle gap inside a frame; reaching TIMEOUT throws the partial frame away
        if (state_q != IDLE && !pmod_valid) begin
            gapCnt_d = gapCnt_q + 8'd1;
            if (gapCnt_q == 8'(TIMEOUT - 1)) begin
                errEvt    = 1'b1;
                state_d   = IDLE;
                gapCnt_d  = '0;
                byteCnt_d = '0;
`ifdef PMOD_RX_HDR_CHECK_EN
                hdrCnt_d  = '0;
`endif
            end
        end

        if (shiftByte) begin
            asm_d = {asm_q[W-9:0], pmod_input};
            if (byteCnt_q == BCW'(NBYTES - 1)) begin
                complete  = 1'b1;
                byteCnt_d = '0;
                state_d   = IDLE;
            end else begin
                byteCnt_d = byteCnt_q + BCW'(1);
                state_d   = DATA;
            end
        end

        if (accept) begin
            bufValid_d = 1'b0;
        end
        if (complete) begin
            frameCnt_d = frameCnt_q + 4'd1;
            if (!bufValid_q || accept) begin
                buf_d      = asm_d;
                bufValid_d = 1'b1;
            end else begin
                errEvt = 1'b1;
            end
        end

        frameErr_d = errEvt;
        if (errEvt && errCnt_q != 4'hF) begin
            errCnt_d = errCnt_q + 4'd1;
        end
    end

    assign word_tdata  = buf_q;
    assign word_tvalid = bufValid_q;
    assign frame_err   = frameErr_q;
    assign led_output  = {errCnt_q, frameCnt_q};

endmodule

// File: tb/tb_pmod_byte_deserializer.sv
// Scoreboard bench for pmod_byte_deserializer: directed frames plus randomized byte streams.
// Honours `define PMOD_RX_HDR_CHECK_EN the same way as the design.
module tb_pmod_byte_deserializer;

    localparam int NBYTES    = 32;
    localparam int HDR_BYTES = 4;
    localparam int TIMEOUT   = 16;
    localparam int W         = 8 * NBYTES;

    logic           aclk = 1'b0;
    logic           areset = 1'b1;
    logic [7:0]     pmod_input = 8'h00;
    logic           pmod_valid = 1'b0;
    logic           word_tready = 1'b0;
    logic [W-1:0]   word_tdata;
    logic           word_tvalid;
    logic           frame_err;
    logic [7:0]     led_output;

    int checks = 0;
    int errors = 0;
    bit monitorOn = 1'b0;

    // Reference model: frame contents as a byte queue, expected words as a FIFO
    logic [W-1:0] expWords[$];
    logic [7:0]   mData[$];
    bit           mInFrame = 1'b0;
    int           mHdrLeft = 0;
    int           mGap = 0;
    bit           mBufFull = 1'b0;
    int           mErrCnt = 0;
    int           mFrameCnt = 0;
    bit           nxtErr = 1'b0, nxtValid = 1'b0;
    logic [7:0]   nxtLed = 8'h00;
    bit           expErr = 1'b0, expValid = 1'b0;
    logic [7:0]   expLed = 8'h00;

    always #5 aclk = ~aclk;

    pmod_byte_deserializer #(
        .NBYTES(NBYTES),
        .HDR_BYTES(HDR_BYTES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .pmod_input(pmod_input),
        .pmod_valid(pmod_valid),
        .word_tdata(word_tdata),
        .word_tvalid(word_tvalid),
        .word_tready(word_tready),
        .frame_err(frame_err),
        .led_output(led_output)
    );

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void abortFrame();
        mInFrame = 1'b0;
        mHdrLeft = 0;
        mGap = 0;
        mData.delete();
    endfunction

    function automatic void modelStep(input bit v, input logic [7:0] b, input bit rdy, input bit rst);
        bit err;
        bit acc;
        bit done;
        logic [W-1:0] word;
        err = 1'b0;
        done = 1'b0;
        word = '0;
        if (rst) begin
            abortFrame();
            expWords.delete();
            mBufFull = 1'b0;
            mErrCnt = 0;
            mFrameCnt = 0;
            nxtErr = 1'b0;
            nxtValid = 1'b0;
            nxtLed = 8'h00;
            return;
        end
        acc = mBufFull && rdy;
        if (!mInFrame) begin
            if (v) begin
`ifdef PMOD_RX_HDR_CHECK_EN
                if (b != 8'h00) err = 1'b1;
                else begin
                    mInFrame = 1'b1;
                    mHdrLeft = HDR_BYTES - 1;
                end
`else
                mInFrame = 1'b1;
                mData.push_back(b);
`endif
            end
        end else if (v) begin
            mGap = 0;
            if (mHdrLeft > 0) begin
                if (b != 8'h00) begin
                    err = 1'b1;
                    abortFrame();
                end else begin
                    mHdrLeft--;
                end
            end else begin
                mData.push_back(b);
            end
        end else begin
            mGap++;
            if (mGap == TIMEOUT) begin
                err = 1'b1;
                abortFrame();
            end
        end
        if (mData.size() == NBYTES) begin
            done = 1'b1;
            foreach (mData[i]) word = (word << 8) | W'(mData[i]);
            abortFrame();
        end
        if (acc) mBufFull = 1'b0;
        if (done) begin
            mFrameCnt = (mFrameCnt + 1) % 16;
            if (!mBufFull) begin
                expWords.push_back(word);
                mBufFull = 1'b1;
            end else begin
                err = 1'b1;
            end
        end
        if (err && mErrCnt < 15) mErrCnt++;
        nxtErr = err;
        nxtValid = mBufFull;
        nxtLed = {mErrCnt[3:0], mFrameCnt[3:0]};
    endfunction

    task automatic applyStimulus(input bit v, input logic [7:0] b, input bit rdy, input bit rst);
        @(posedge aclk);
        #1;
        expErr = nxtErr;
        expValid = nxtValid;
        expLed = nxtLed;
        pmod_valid = v;
        pmod_input = b;
        word_tready = rdy;
        areset = rst;
        modelStep(v, b, rdy, rst);
    endtask

    task automatic sendHeader(input bit rdy);
`ifdef PMOD_RX_HDR_CHECK_EN
        for (int i = 0; i < HDR_BYTES; i++) applyStimulus(1'b1, 8'h00, rdy, 1'b0);
`endif
    endtask

    task automatic sendFrame(input logic [7:0] base, input bit rdy, input bit rdyLast);
        sendHeader(rdy);
        for (int i = 0; i < NBYTES; i++)
            applyStimulus(1'b1, base + 8'(i), (i == NBYTES - 1) ? rdyLast : rdy, 1'b0);
    endtask

    task automatic idleCycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, rdy, 1'b0);
    endtask

    // Monitor: status outputs every cycle, word contents on every handshake
    always @(negedge aclk) begin
        if (monitorOn) begin
            checkOutput("word_tvalid", W'(word_tvalid), W'(expValid));
            checkOutput("frame_err", W'(frame_err), W'(expErr));
            checkOutput("led_output", W'(led_output), W'(expLed));
            if (word_tvalid && word_tready && !areset) begin
                if (expWords.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL word_tdata: got %0h expected no word", word_tdata);
                end else begin
                    checkOutput("word_tdata", word_tdata, expWords.pop_front());
                end
            end
        end
    end

    initial begin
        int idleLeft;
        bit v;
        logic [7:0] b;

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        monitorOn = 1'b1;
        @(negedge aclk);
        checkOutput("reset word_tdata", word_tdata, '0);

        $display("[TB] clean frame 01..20");
        sendFrame(8'h01, 1'b1, 1'b1);
        idleCycles(3, 1'b1);

`ifdef PMOD_RX_HDR_CHECK_EN
        $display("[TB] bad header byte");
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
        idleCycles(2, 1'b1);
        sendFrame(8'h40, 1'b1, 1'b1);
        idleCycles(2, 1'b1);
`endif

        $display("[TB] timeout after data byte 10");
        sendHeader(1'b1);
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
        idleCycles(TIMEOUT + 2, 1'b1);
        sendFrame(8'h60, 1'b1, 1'b1);
        idleCycles(2, 1'b1);

        $display("[TB] back-to-back frames with consumer stalled");
        sendFrame(8'h10, 1'b0, 1'b0);
        sendFrame(8'h80, 1'b0, 1'b0);
        idleCycles(2, 1'b0);
        idleCycles(3, 1'b1);

        $display("[TB] drain on the completion cycle");
        sendFrame(8'h20, 1'b0, 1'b0);
        sendFrame(8'hC0, 1'b0, 1'b1);
        idleCycles(3, 1'b1);

        $display("[TB] reset mid-frame");
        sendHeader(1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        sendFrame(8'h05, 1'b1, 1'b1);
        idleCycles(2, 1'b1);

        $display("[TB] randomized stream");
        idleLeft = 0;
        for (int c = 0; c < 4000; c++) begin
            if (idleLeft > 0) begin
                idleLeft--;
                v = 1'b0;
            end else if ($urandom_range(0, 63) == 0) begin
                idleLeft = $urandom_range(5, 20);
                v = 1'b0;
            end else begin
                v = ($urandom_range(0, 7) != 0);
            end
`ifdef PMOD_RX_HDR_CHECK_EN
            b = ($urandom_range(0, 3) != 0) ? 8'h00 : 8'($urandom);
`else
            b = 8'($urandom);
`endif
            applyStimulus(v, b, 1'($urandom), ($urandom_range(0, 999) == 0));
        end

        idleCycles(TIMEOUT + 4, 1'b1);
        @(negedge aclk);
        checks++;
        if (expWords.size() != 0) begin
            errors++;
            $display("[TB] FAIL words drained: got %0d pending expected 0", expWords.size());
        end
        monitorOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
